gps_ftdi_bus_sched: RTL and testbench
=====================================

Name: gps_ftdi_bus_sched

Overview:
- Scheduler that shares one AXI4-Lite master port between two requesters.
  - RX side: polls the GPS UART Lite and pulls received bytes into an internal byte FIFO.
  - TX side: polls the FTDI UART Lite and pushes FIFO bytes into its TX FIFO.
- Optional NMEA filter: only bytes from '$' up to and including LF are forwarded.
- Sits between the board-level AXI-Lite interconnect (GPS at GPS_BASE, FTDI at FTDI_BASE) and replaces per-UART polling FSMs.

Parameters:
- ADDR_W, 5, AXI address width (bits [ADDR_W-1:4] select the UART, bits [3:0] the register).
- GPS_BASE, 5'h00, GPS UART Lite base address.
- FTDI_BASE, 5'h10, FTDI UART Lite base address.
- FIFO_DEPTH, 16, internal byte FIFO entries (power of two).
- FILTER_NMEA, 1, 1 = drop bytes outside '$'..LF; 0 = forward all bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AW_addr  out  ADDR_W  write address
- AW_valid  out  1
- AW_ready  in  1
- W_data  out  32  write data, byte in [7:0], upper bits 0
- W_valid  out  1
- W_ready  in  1
- B_resp  in  2
- B_valid  in  1
- B_ready  out  1
- AR_addr  out  ADDR_W
- AR_valid  out  1
- AR_ready  in  1
- R_data  in  32
- R_valid  in  1
- R_ready  out  1
- sentence_done  out  1  one-cycle pulse when an LF is pushed into the FIFO
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- bus_err  out  1  sticky; set on any B_resp/R_resp != 2'b00 (R_resp is not ported, so only B_resp is checked); cleared only by rst
- drop_cnt  out  16  saturating count of bytes dropped (filter or FIFO full)

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. All valids/readies, sentence_done and bus_err are 0. Addresses, W_data, drop_cnt and fifo_level are 0. FSM goes to IDLE; FIFO is emptied; in_sentence=0; gps_rx_valid=0; ftdi_tx_free=0; rr=RX.
- UART Lite register map: RX FIFO +0x0, TX FIFO +0x4, STAT +0x8.
  - STAT[0] = RX valid.
  - STAT[3] = TX full.
- Jobs, evaluated in IDLE:
  - RX_STAT: read GPS STAT; eligible when FIFO not full.
  - RX_DATA: read GPS RX; eligible when gps_rx_valid and FIFO not full.
  - TX_STAT: read FTDI STAT; eligible when FIFO not empty.
  - TX_DATA: write FTDI TX; eligible when ftdi_tx_free and FIFO not empty.
- Arbitration:
  - RX side offers RX_DATA if eligible, else RX_STAT. TX side offers TX_DATA if eligible, else TX_STAT.
  - Round-robin between sides via rr; rr flips to the other side after each granted job. If only one side is eligible, it is granted regardless of rr.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
  - IDLE -> RD_ADDR (read job) or WR_ADDR (TX_DATA). Issue takes 1 cycle from grant: AR_valid (or AW_valid and W_valid) high the cycle after the grant.
  - RD_ADDR: AR_valid held until AR_ready. Then -> RD_DATA.
  - RD_DATA: R_ready=1 while in state; on R_valid, capture the result and -> IDLE.
  - WR_ADDR: AW_valid and W_valid raised together. Each drops independently on its own ready (same-cycle readies allowed). When both accepted -> WR_RESP.
  - WR_RESP: B_ready=1; on B_valid -> IDLE. A non-zero B_resp sets bus_err; the byte is still considered consumed.
- Capture rules:
  - RX_STAT: gps_rx_valid <= R_data[0].
  - TX_STAT: ftdi_tx_free <= ~R_data[3].
  - RX_DATA: gps_rx_valid <= 0, then the byte is filtered and pushed.
  - TX_DATA: FIFO pop on B handshake; ftdi_tx_free <= 0, which forces a fresh STAT before the next write.
- Filter (FILTER_NMEA=1):
  - '$' (0x24) sets in_sentence and is pushed; a '$' mid-sentence restarts the sentence and is still pushed.
  - Other bytes are pushed only while in_sentence.
  - LF (0x0A) is pushed, then clears in_sentence and pulses sentence_done the cycle after the push.
  - Non-pushed bytes increment drop_cnt (saturates at 0xFFFF).
- FIFO:
  - A push into a full FIFO never happens: RX_DATA is not eligible when full.
  - Push and pop in the same cycle keep fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- W_data = {24'b0, fifo_head}, stable from issue until W handshake.
- rst mid-transaction abandons the transfer immediately; the interconnect is reset by the same rst.

Decomposition:
- Package gps_bus_pkg holds:
  - sched_state_t and job_t enums;
  - UART register offsets (RX_OFS=4'h0, TX_OFS=4'h4, STAT_OFS=4'h8);
  - STAT bit indices (RX_VALID_BIT=0, TX_FULL_BIT=3);
  - NMEA_START=8'h24, NMEA_END=8'h0A.
- One sub-module: byte_fifo (parameterised depth, push/pop/full/empty/level, synchronous reset).

Test Plan:
- Idle slaves (STAT reads 0x00): scheduler loops RX_STAT only; AR_addr=0x08 each poll; no AW_valid; fifo_level=0.
- GPS stream "$GP\n" with FTDI STAT=0x00: four bytes reach FTDI with AW_addr=0x14 and W_data 0x24, 0x47, 0x50, 0x0A in order; sentence_done pulses once; drop_cnt=0.
- Bytes "xy$A\n" with FILTER_NMEA=1: drop_cnt=2; FTDI receives only 0x24, 0x41, 0x0A.
- FTDI STAT=0x08 (TX full) while 20 bytes arrive: fifo_level stops at 16; RX_DATA is not issued while full. When STAT becomes 0x00, the FIFO drains in order.
- AR_ready delayed 3 cycles and AW_ready/W_ready asserted in different cycles: valids are held until each handshake; exactly one transaction per job.
- B_resp=2'b10 on one write: bus_err=1 and stays 1; the FIFO still pops that byte. rst mid-RD_ADDR: all outputs are 0 the next cycle and fifo_level=0.

Source files
------------

// File: rtl/gps_bus_pkg.sv
// Shared types and constants for the GPS/FTDI AXI-Lite bus scheduler.
// Covers the UART Lite register map, the NMEA sentence delimiters and the job encoding.
package gps_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_RESP
  } sched_state_t;

  typedef enum logic [1:0] {
    J_RX_STAT,
    J_RX_DATA,
    J_TX_STAT,
    J_TX_DATA
  } job_t;

  localparam logic [3:0] RX_OFS   = 4'h0;
  localparam logic [3:0] TX_OFS   = 4'h4;
  localparam logic [3:0] STAT_OFS = 4'h8;

  localparam int RX_VALID_BIT = 0;
  localparam int TX_FULL_BIT  = 3;

  localparam logic [7:0] NMEA_START = 8'h24;
  localparam logic [7:0] NMEA_END   = 8'h0A;

  localparam logic SIDE_RX = 1'b0;
  localparam logic SIDE_TX = 1'b1;

  function automatic logic is_rx_job(job_t j);
    return (j == J_RX_STAT) || (j == J_RX_DATA);
  endfunction

  function automatic logic [3:0] job_ofs(job_t j);
    logic [3:0] ofs;
    case (j)
      J_RX_DATA: ofs = RX_OFS;
      J_TX_DATA: ofs = TX_OFS;
      default:   ofs = STAT_OFS;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with synchronous reset.
// Pointers wrap naturally at the power-of-two depth; the head entry is presented combinationally.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/gps_ftdi_bus_sched.sv
// Shares one AXI4-Lite master between a GPS RX poller and an FTDI TX poller,
// moving bytes through an internal FIFO with an optional NMEA sentence filter.
//
// state     | meaning
// IDLE      | pick the next job (round-robin between RX and TX sides)
// RD_ADDR   | AR_valid held until AR_ready
// RD_DATA   | R_ready high, wait for R_valid and capture the result
// WR_ADDR   | AW_valid/W_valid held, each dropping on its own ready
// WR_RESP   | B_ready high, wait for B_valid; pop the transmitted byte
module gps_ftdi_bus_sched
  import gps_bus_pkg::*;
#(
  parameter int                ADDR_W      = 5,
  parameter logic [ADDR_W-1:0] GPS_BASE    = 5'h00,
  parameter logic [ADDR_W-1:0] FTDI_BASE   = 5'h10,
  parameter int                FIFO_DEPTH  = 16,
  parameter bit                FILTER_NMEA = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ADDR_W-1:0]             AW_addr,
  output logic                          AW_valid,
  input  logic                          AW_ready,
  output logic [31:0]                   W_data,
  output logic                          W_valid,
  input  logic                          W_ready,
  input  logic [1:0]                    B_resp,
  input  logic                          B_valid,
  output logic                          B_ready,
  output logic [ADDR_W-1:0]             AR_addr,
  output logic                          AR_valid,
  input  logic                          AR_ready,
  input  logic [31:0]                   R_data,
  input  logic                          R_valid,
  output logic                          R_ready,
  output logic                          sentence_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          bus_err,
  output logic [15:0]                   drop_cnt
);

  sched_state_t r_state;
  job_t         r_job;
  logic         r_rr;
  logic         r_gps_rx_valid;
  logic         r_ftdi_tx_free;
  logic         r_in_sentence;

  logic         w_full;
  logic         w_empty;
  logic [7:0]   w_head;
  logic [7:0]   w_rx_byte;
  logic         w_rx_hs;
  logic         w_b_hs;
  logic         w_is_start;
  logic         w_is_end;
  logic         w_keep;
  logic         w_push;
  logic         w_pop;
  logic         w_rx_elig;
  logic         w_tx_elig;
  logic         w_pick_tx;
  job_t         w_grant_job;
  logic [ADDR_W-1:0] w_grant_addr;
  logic         w_unused;

  assign w_unused   = ^R_data[31:8];
  assign w_rx_byte  = R_data[7:0];
  assign w_rx_hs    = (r_state == S_RD_DATA) && R_valid;
  assign w_b_hs     = (r_state == S_WR_RESP) && B_valid;
  assign w_is_start = (w_rx_byte == NMEA_START);
  assign w_is_end   = (w_rx_byte == NMEA_END);
  assign w_keep     = FILTER_NMEA ? (w_is_start || r_in_sentence) : 1'b1;
  assign w_push     = w_rx_hs && (r_job == J_RX_DATA) && w_keep;
  assign w_pop      = w_b_hs;

  // RX_STAT and RX_DATA both need FIFO room; both TX jobs need a byte to send.
  always_comb begin
    w_rx_elig    = !w_full;
    w_tx_elig    = !w_empty;
    w_pick_tx    = w_tx_elig && (!w_rx_elig || (r_rr == SIDE_TX));
    w_grant_job  = J_RX_STAT;
    w_grant_addr = '0;
    if (w_pick_tx) w_grant_job = r_ftdi_tx_free ? J_TX_DATA : J_TX_STAT;
    else           w_grant_job = r_gps_rx_valid ? J_RX_DATA : J_RX_STAT;
    w_grant_addr = (is_rx_job(w_grant_job) ? GPS_BASE : FTDI_BASE)
                   | ADDR_W'(job_ofs(w_grant_job));
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_rx_byte),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_job          <= J_RX_STAT;
      r_rr           <= SIDE_RX;
      r_gps_rx_valid <= 1'b0;
      r_ftdi_tx_free <= 1'b0;
      r_in_sentence  <= 1'b0;
      AW_addr        <= '0;
      AW_valid       <= 1'b0;
      W_data         <= '0;
      W_valid        <= 1'b0;
      B_ready        <= 1'b0;
      AR_addr        <= '0;
      AR_valid       <= 1'b0;
      R_ready        <= 1'b0;
      sentence_done  <= 1'b0;
      bus_err        <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      sentence_done <= w_push && w_is_end;
      case (r_state)
        S_IDLE: begin
          if (w_rx_elig || w_tx_elig) begin
            r_job <= w_grant_job;
            r_rr  <= w_pick_tx ? SIDE_RX : SIDE_TX;
            if (w_grant_job == J_TX_DATA) begin
              AW_addr  <= w_grant_addr;
              AW_valid <= 1'b1;
              W_data   <= {24'b0, w_head};
              W_valid  <= 1'b1;
              r_state  <= S_WR_ADDR;
            end else begin
              AR_addr  <= w_grant_addr;
              AR_valid <= 1'b1;
              r_state  <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (AR_ready) begin
            AR_valid <= 1'b0;
            R_ready  <= 1'b1;
            r_state  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (R_valid) begin
            R_ready <= 1'b0;
            r_state <= S_IDLE;
            case (r_job)
              J_RX_STAT: r_gps_rx_valid <= R_data[RX_VALID_BIT];
              J_TX_STAT: r_ftdi_tx_free <= ~R_data[TX_FULL_BIT];
              J_RX_DATA: begin
                r_gps_rx_valid <= 1'b0;
                if (w_is_start)    r_in_sentence <= 1'b1;
                else if (w_is_end) r_in_sentence <= 1'b0;
                if (!w_keep && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_WR_ADDR: begin
          if (AW_ready) AW_valid <= 1'b0;
          if (W_ready)  W_valid  <= 1'b0;
          if ((!AW_valid || AW_ready) && (!W_valid || W_ready)) begin
            B_ready <= 1'b1;
            r_state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          // The byte counts as sent even on an error response, so it is popped anyway.
          if (B_valid) begin
            B_ready        <= 1'b0;
            r_ftdi_tx_free <= 1'b0;
            if (B_resp != 2'b00) bus_err <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_ftdi_bus_sched.sv
// Bench for gps_ftdi_bus_sched: behavioural GPS/FTDI UART Lite slaves plus a
// scoreboard of bytes expected at the FTDI TX register, checked by a negedge monitor.
module tb_gps_ftdi_bus_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  AW_addr;
  logic        AW_valid;
  logic        AW_ready;
  logic [31:0] W_data;
  logic        W_valid;
  logic        W_ready;
  logic [1:0]  B_resp;
  logic        B_valid;
  logic        B_ready;
  logic [4:0]  AR_addr;
  logic        AR_valid;
  logic        AR_ready;
  logic [31:0] R_data;
  logic        R_valid;
  logic        R_ready;
  logic        sentence_done;
  logic [4:0]  fifo_level;
  logic        bus_err;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  gps_ftdi_bus_sched dut (
    .clk(clk), .rst(rst),
    .AW_addr(AW_addr), .AW_valid(AW_valid), .AW_ready(AW_ready),
    .W_data(W_data), .W_valid(W_valid), .W_ready(W_ready),
    .B_resp(B_resp), .B_valid(B_valid), .B_ready(B_ready),
    .AR_addr(AR_addr), .AR_valid(AR_valid), .AR_ready(AR_ready),
    .R_data(R_data), .R_valid(R_valid), .R_ready(R_ready),
    .sentence_done(sentence_done), .fifo_level(fifo_level),
    .bus_err(bus_err), .drop_cnt(drop_cnt)
  );

  // slave configuration (stimulus writes, slaves read)
  logic [7:0] gps_q[$];
  logic [7:0] exp_q[$];
  bit ftdi_full = 1'b0;
  int ar_delay  = 0;
  int aw_delay  = 0;
  int w_delay   = 0;
  int err_at    = -1;

  // monitor / slave statistics (each written by exactly one process)
  int b_total = 0;
  int ar_hs = 0, ar_gps_stat = 0, ar_other = 0, ar_gps_full = 0;
  int r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, sd_cnt = 0, viol = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // read slave: optional AR_ready delay, R one cycle after the address handshake
  initial begin
    int rd_st;
    int ar_cnt;
    rd_st = 0; ar_cnt = 0;
    AR_ready = 1'b0; R_valid = 1'b0; R_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        rd_st = 0; AR_ready = 1'b0; R_valid = 1'b0;
      end else begin
        case (rd_st)
          0: if (AR_valid) begin
               if (ar_delay == 0) begin AR_ready = 1'b1; rd_st = 2; end
               else begin ar_cnt = ar_delay; rd_st = 1; end
             end
          1: begin
               ar_cnt--;
               if (ar_cnt == 0) begin AR_ready = 1'b1; rd_st = 2; end
             end
          2: begin
               AR_ready = 1'b0;
               if (AR_addr == 5'h08)      R_data = {31'b0, (gps_q.size() != 0)};
               else if (AR_addr == 5'h00) R_data = (gps_q.size() != 0) ? {24'b0, gps_q.pop_front()} : 32'h0;
               else if (AR_addr == 5'h18) R_data = ftdi_full ? 32'h8 : 32'h0;
               else                       R_data = 32'h0;
               R_valid = 1'b1;
               rd_st = 3;
             end
          default: begin R_valid = 1'b0; rd_st = 0; end
        endcase
      end
    end
  end

  // write slave: independent AW/W ready delays, B after both are accepted
  initial begin
    int wst, aw_cnt, w_cnt;
    bit aw_got, w_got;
    wst = 0; aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
    AW_ready = 1'b0; W_ready = 1'b0; B_valid = 1'b0; B_resp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        wst = 0; AW_ready = 1'b0; W_ready = 1'b0; B_valid = 1'b0; B_resp = 2'b00;
      end else begin
        if (wst == 0 && AW_valid) begin
          aw_cnt = aw_delay; w_cnt = w_delay; aw_got = 0; w_got = 0; wst = 1;
        end
        if (wst == 1) begin
          if (AW_ready) begin AW_ready = 1'b0; aw_got = 1; end
          else if (!aw_got) begin if (aw_cnt == 0) AW_ready = 1'b1; else aw_cnt--; end
          if (W_ready) begin W_ready = 1'b0; w_got = 1; end
          else if (!w_got) begin if (w_cnt == 0) W_ready = 1'b1; else w_cnt--; end
          if (aw_got && w_got) begin
            b_total++;
            B_resp  = (b_total == err_at) ? 2'b10 : 2'b00;
            B_valid = 1'b1;
            wst = 2;
          end
        end else if (wst == 2) begin
          B_valid = 1'b0; B_resp = 2'b00; wst = 0;
        end
      end
    end
  end

  // monitor: handshakes, scoreboard pops and valid-hold protocol checks
  initial begin
    bit ar_pend, aw_pend, w_pend;
    logic [31:0] w_prev;
    ar_pend = 0; aw_pend = 0; w_pend = 0; w_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_pend = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (ar_pend && !AR_valid) viol++;
        if (aw_pend && !AW_valid) viol++;
        if (w_pend && (!W_valid || W_data != w_prev)) viol++;
        if (AR_valid && AR_ready) begin
          ar_hs++;
          if (AR_addr == 5'h08) ar_gps_stat++; else ar_other++;
          if (AR_addr < 5'h10 && fifo_level == 5'd16) ar_gps_full++;
        end
        if (R_valid && R_ready) r_hs++;
        if (AW_valid && AW_ready) begin
          aw_hs++;
          check("aw_addr", {27'b0, AW_addr}, 32'h14);
        end
        if (W_valid && W_ready) begin
          w_hs++;
          if (exp_q.size() == 0) check("w_unexpected", W_data, 32'hFFFF_FFFF);
          else                   check("w_data", W_data, {24'b0, exp_q.pop_front()});
        end
        if (B_valid && B_ready) b_hs++;
        if (sentence_done) sd_cnt++;
        ar_pend = AR_valid && !AR_ready;
        aw_pend = AW_valid && !AW_ready;
        w_pend  = W_valid && !W_ready;
        w_prev  = W_data;
      end
    end
  end

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) gps_q.push_back(s[i]);
  endtask

  task automatic expect_bytes(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic drain(string name, int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || gps_q.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_in_time"}, {31'b0, (t < budget)}, 32'h1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ar_valid"}, {31'b0, AR_valid}, 0);
    check({tag, "_aw_valid"}, {31'b0, AW_valid}, 0);
    check({tag, "_w_valid"},  {31'b0, W_valid}, 0);
    check({tag, "_b_ready"},  {31'b0, B_ready}, 0);
    check({tag, "_r_ready"},  {31'b0, R_ready}, 0);
    check({tag, "_sdone"},    {31'b0, sentence_done}, 0);
    check({tag, "_bus_err"},  {31'b0, bus_err}, 0);
    check({tag, "_ar_addr"},  {27'b0, AR_addr}, 0);
    check({tag, "_aw_addr"},  {27'b0, AW_addr}, 0);
    check({tag, "_w_data"},   W_data, 0);
    check({tag, "_drop_cnt"}, {16'b0, drop_cnt}, 0);
    check({tag, "_level"},    {27'b0, fifo_level}, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_gps, s_oth, s_aw, s_w, s_b, s_sd, s_viol, s_ar, s_r, s_full, t;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // idle slaves: only GPS STAT polls
    s_gps = ar_gps_stat; s_oth = ar_other; s_aw = aw_hs;
    repeat (40) @(negedge clk);
    check("idle_polls_ge5", {31'b0, (ar_gps_stat - s_gps >= 5)}, 1);
    check("idle_ar_other", ar_other - s_oth, 0);
    check("idle_aw", aw_hs - s_aw, 0);
    check("idle_level", {27'b0, fifo_level}, 0);

    // "$GP\n" forwarded unchanged
    s_sd = sd_cnt; s_aw = aw_hs; s_w = w_hs;
    send("$GP\n"); expect_bytes("$GP\n");
    drain("gp", 1000);
    check("gp_sdone", sd_cnt - s_sd, 1);
    check("gp_drop", {16'b0, drop_cnt}, 0);
    check("gp_aw", aw_hs - s_aw, 4);
    check("gp_w", w_hs - s_w, 4);

    // leading junk is dropped
    s_sd = sd_cnt;
    send("xy$A\n"); expect_bytes("$A\n");
    drain("xy", 1000);
    check("xy_drop", {16'b0, drop_cnt}, 2);
    check("xy_sdone", sd_cnt - s_sd, 1);

    // FTDI full: FIFO saturates at 16, GPS not polled while full, then drains in order
    ftdi_full = 1'b1;
    s_w = w_hs; s_full = ar_gps_full;
    for (int i = 0; i < 20; i++) begin
      gps_q.push_back((i == 0) ? 8'h24 : 8'(8'h40 + i));
      exp_q.push_back((i == 0) ? 8'h24 : 8'(8'h40 + i));
    end
    t = 0;
    while (fifo_level != 5'd16 && t < 1000) begin @(negedge clk); t++; end
    check("full_reached", {31'b0, (t < 1000)}, 1);
    repeat (60) @(negedge clk);
    check("full_level", {27'b0, fifo_level}, 16);
    check("full_gps_left", gps_q.size(), 4);
    check("full_no_gps_ar", ar_gps_full - s_full, 0);
    check("full_no_write", w_hs - s_w, 0);
    ftdi_full = 1'b0;
    drain("full", 2000);
    check("full_drained_level", {27'b0, fifo_level}, 0);

    // handshake delays: AR late, AW and W ready in different cycles
    ar_delay = 3; aw_delay = 1; w_delay = 3;
    s_viol = viol; s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_ar = ar_hs; s_r = r_hs;
    send("$B\n"); expect_bytes("$B\n");
    drain("dly", 3000);
    check("dly_viol", viol - s_viol, 0);
    check("dly_aw", aw_hs - s_aw, 3);
    check("dly_w", w_hs - s_w, 3);
    check("dly_b", b_hs - s_b, 3);
    check("dly_ar_eq_r", ar_hs - s_ar, r_hs - s_r);
    ar_delay = 0; aw_delay = 0; w_delay = 0;

    // error response on the second write of this sentence
    err_at = b_total + 2;
    s_w = w_hs;
    send("$C\n"); expect_bytes("$C\n");
    drain("err", 1000);
    check("err_bus_err", {31'b0, bus_err}, 1);
    check("err_w", w_hs - s_w, 3);
    check("err_level", {27'b0, fifo_level}, 0);
    repeat (30) @(negedge clk);
    check("err_sticky", {31'b0, bus_err}, 1);
    check("err_drop", {16'b0, drop_cnt}, 2);

    // reset during RD_ADDR with bytes held in the FIFO
    ftdi_full = 1'b1;
    send("$DE");
    t = 0;
    while (fifo_level != 5'd3 && t < 500) begin @(negedge clk); t++; end
    check("rst_fill", {31'b0, (t < 500)}, 1);
    ar_delay = 20;
    t = 0;
    while (!(AR_valid && !AR_ready) && t < 100) begin @(negedge clk); t++; end
    check("rst_ar_pending", {31'b0, (t < 100)}, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    ar_delay = 0; ftdi_full = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // after reset the sentence state is cleared, so leading 'z' is dropped
    s_sd = sd_cnt;
    send("z$E\n"); expect_bytes("$E\n");
    drain("post", 1000);
    check("post_drop", {16'b0, drop_cnt}, 1);
    check("post_sdone", sd_cnt - s_sd, 1);
    check("post_bus_err", {31'b0, bus_err}, 0);
    check("post_exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
